// File: rtl/median9_node_scheduler.sv
// -----------------------------------------------------------------------------
// median9_node_scheduler
//
// Sequential median-of-9 engine. One combinational compare-exchange node is
// reused across the 19 steps of the optimal median-of-9 sorting network, so a
// median takes 19 RUN cycles plus the output handshake instead of nineteen
// parallel comparators.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   valid_i   in   3x3 window on data_i is valid
//   ready_o   out  engine can accept a window
//   data_i    in   9 pixels, pixel k at data_i[k*DATA_WIDTH +: DATA_WIDTH]
//   median_o  out  registered median result
//   valid_o   out  median_o valid
//   ready_i   in   downstream accepts the result
//   busy_o    out  window in flight (RUN or DONE)
//
// Optional build macro: MEDIAN9_SCHED_BACK_TO_BACK_EN
//   When defined, DONE can hand off its result and accept the next window on
//   the same edge (20-cycle period). When undefined, DONE always returns to
//   IDLE first (21-cycle period).
// -----------------------------------------------------------------------------

module median9_node (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] min_o,
   output logic [7:0] max_o
);
   // Unsigned compare; on a tie both outputs carry the same value.
   assign min_o = (a_i <= b_i) ? a_i : b_i;
   assign max_o = (a_i <= b_i) ? b_i : a_i;
endmodule

module median9_node_scheduler #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic [9*DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0]   median_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    busy_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [4:0] LAST_STEP = 5'd18;

   state_t                state_q;
   logic [4:0]            step_q;
   logic [DATA_WIDTH-1:0] p_q [0:8];
   logic [DATA_WIDTH-1:0] median_q;
   logic                  valid_q;

   logic [3:0]            idx_a;
   logic [3:0]            idx_b;
   logic [DATA_WIDTH-1:0] node_min;
   logic [DATA_WIDTH-1:0] node_max;
   logic [DATA_WIDTH-1:0] p4_d;
   logic                  accept;

   // Schedule ROM: compare-exchange pair for each network step.
   always_comb begin
      idx_a = 4'd4;
      idx_b = 4'd4;
      case (step_q)
         5'd0:  begin idx_a = 4'd1; idx_b = 4'd2; end
         5'd1:  begin idx_a = 4'd4; idx_b = 4'd5; end
         5'd2:  begin idx_a = 4'd7; idx_b = 4'd8; end
         5'd3:  begin idx_a = 4'd0; idx_b = 4'd1; end
         5'd4:  begin idx_a = 4'd3; idx_b = 4'd4; end
         5'd5:  begin idx_a = 4'd6; idx_b = 4'd7; end
         5'd6:  begin idx_a = 4'd1; idx_b = 4'd2; end
         5'd7:  begin idx_a = 4'd4; idx_b = 4'd5; end
         5'd8:  begin idx_a = 4'd7; idx_b = 4'd8; end
         5'd9:  begin idx_a = 4'd0; idx_b = 4'd3; end
         5'd10: begin idx_a = 4'd5; idx_b = 4'd8; end
         5'd11: begin idx_a = 4'd4; idx_b = 4'd7; end
         5'd12: begin idx_a = 4'd3; idx_b = 4'd6; end
         5'd13: begin idx_a = 4'd1; idx_b = 4'd4; end
         5'd14: begin idx_a = 4'd2; idx_b = 4'd5; end
         5'd15: begin idx_a = 4'd4; idx_b = 4'd7; end
         5'd16: begin idx_a = 4'd4; idx_b = 4'd2; end
         5'd17: begin idx_a = 4'd6; idx_b = 4'd4; end
         5'd18: begin idx_a = 4'd4; idx_b = 4'd2; end
         default: begin idx_a = 4'd4; idx_b = 4'd4; end
      endcase
   end

   median9_node u_node (
      .a_i   (p_q[idx_a]),
      .b_i   (p_q[idx_b]),
      .min_o (node_min),
      .max_o (node_max)
   );

   // Value p[4] will hold after this step's write-back; captured as the
   // result on the final step so median_o is ready on the RUN->DONE edge.
   always_comb begin
      p4_d = p_q[4];
      if (idx_b == 4'd4) p4_d = node_max;
      if (idx_a == 4'd4) p4_d = node_min;
   end

`ifdef MEDIAN9_SCHED_BACK_TO_BACK_EN
   assign ready_o = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
`else
   assign ready_o = (state_q == S_IDLE);
`endif

   assign accept   = valid_i && ready_o;
   assign busy_o   = (state_q != S_IDLE);
   assign median_o = median_q;
   assign valid_o  = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         step_q   <= 5'd0;
         median_q <= '0;
         valid_q  <= 1'b0;
         for (int k = 0; k < 9; k++) p_q[k] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  for (int k = 0; k < 9; k++) p_q[k] <= data_i[k*DATA_WIDTH +: DATA_WIDTH];
                  step_q  <= 5'd0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               p_q[idx_a] <= node_min;
               p_q[idx_b] <= node_max;
               if (step_q >= LAST_STEP) begin
                  step_q   <= 5'd0;
                  median_q <= p4_d;
                  valid_q  <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  step_q <= step_q + 5'd1;
               end
            end
            S_DONE: begin
               if (ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
`ifdef MEDIAN9_SCHED_BACK_TO_BACK_EN
                  // Output handshake and next capture share this edge.
                  if (accept) begin
                     for (int k = 0; k < 9; k++) p_q[k] <= data_i[k*DATA_WIDTH +: DATA_WIDTH];
                     step_q  <= 5'd0;
                     state_q <= S_RUN;
                  end
`endif
               end
            end
            default: begin
               step_q  <= 5'd0;
               valid_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_median9_node_scheduler.sv
module tb_median9_node_scheduler;
   localparam int W = 8;
`ifdef MEDIAN9_SCHED_BACK_TO_BACK_EN
   localparam int PERIOD = 20;
`else
   localparam int PERIOD = 21;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           valid_i;
   logic           ready_o;
   logic [9*W-1:0] data_i;
   logic [W-1:0]   median_o;
   logic           valid_o;
   logic           ready_i;
   logic           busy_o;

   int n_pass  = 0;
   int n_total = 0;

   median9_node_scheduler #(.DATA_WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .median_o (median_o),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .busy_o   (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pix[9];
      int med;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      else n_pass++;
   endtask

   function automatic logic [9*W-1:0] pack(input int p[9]);
      logic [9*W-1:0] r;
      int v;
      r = '0;
      for (int k = 0; k < 9; k++) begin
         v = p[k];
         r[k*W +: W] = v[W-1:0];
      end
      return r;
   endfunction

   // Reference: the median is the value with at most 4 strictly smaller
   // entries and at least 5 entries less-or-equal.
   function automatic int ref_median(input int p[9]);
      int lt, le;
      for (int i = 0; i < 9; i++) begin
         lt = 0; le = 0;
         for (int j = 0; j < 9; j++) begin
            if (p[j] < p[i]) lt++;
            if (p[j] <= p[i]) le++;
         end
         if (lt <= 4 && le >= 5) return p[i];
      end
      return -1;
   endfunction

   // Wait for ready_o at a negedge, bounded.
   task automatic wait_ready(input string tag);
      int w;
      w = 0;
      while (!ready_o && w < 60) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_ready"}, int'(ready_o), 1);
   endtask

   // One window with ready_i high: latency, result, pulse width.
   task automatic run_window(input int p[9], input int exp, input string tag);
      int lat;
      int prev;
      wait_ready(tag);
      prev    = int'(median_o);
      ready_i = 1'b1;
      data_i  = pack(p);
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      data_i  = {9*W{1'b1}} ^ pack(p);
      chk({tag, "_busy"}, int'(busy_o), 1);
      chk({tag, "_ready_run"}, int'(ready_o), 0);
      lat = -1;
      for (int k = 0; k <= 40; k++) begin
         if (valid_o) begin
            lat = k;
            break;
         end
         if (k == 18) chk({tag, "_median_hold"}, int'(median_o), prev);
         @(negedge clk);
      end
      chk({tag, "_latency"}, lat, 19);
      chk({tag, "_median"}, int'(median_o), exp);
      @(negedge clk);
      chk({tag, "_pulse"}, int'(valid_o), 0);
      chk({tag, "_idle"}, int'(busy_o), 0);
   endtask

   initial begin
      vec_t tbl[4];
      int   rw[9];
      int   bp[9];
      int   lat;
      int   acc_cyc[$];
      int   expq[$];
      int   nacc, nres;
      logic accepted;

      tbl[0].pix = '{30, 90, 10, 70, 50, 20, 80, 40, 60};    tbl[0].med = 50;
      tbl[1].pix = '{70, 70, 70, 70, 70, 70, 70, 70, 70};    tbl[1].med = 70;
      tbl[2].pix = '{255, 0, 255, 0, 255, 0, 255, 0, 128};   tbl[2].med = 128;
      tbl[3].pix = '{1, 2, 3, 4, 5, 6, 7, 8, 9};             tbl[3].med = 5;

      rst_n   = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      data_i  = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", int'(ready_o), 1);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_median", int'(median_o), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++)
         run_window(tbl[i].pix, tbl[i].med, $sformatf("tbl%0d", i));

      // Backpressure: result held, extra window ignored.
      bp = '{12, 200, 45, 99, 7, 180, 63, 150, 88};
      wait_ready("bp");
      ready_i = 1'b0;
      data_i  = pack(bp);
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      lat = -1;
      for (int k = 0; k <= 40; k++) begin
         if (valid_o) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      chk("bp_latency", lat, 19);
      chk("bp_median", int'(median_o), 88);
      data_i  = pack(tbl[0].pix);
      valid_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp_valid%0d", k), int'(valid_o), 1);
         chk($sformatf("bp_hold%0d", k), int'(median_o), 88);
         chk($sformatf("bp_ready%0d", k), int'(ready_o), 0);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(negedge clk);
      chk("bp_consumed", int'(valid_o), 0);
      chk("bp_idle", int'(busy_o), 0);
      chk("bp_ready_after", int'(ready_o), 1);

      // Reset in the middle of RUN (step 7).
      wait_ready("mr");
      data_i  = pack(tbl[0].pix);
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (7) @(negedge clk);
      chk("mr_busy_before", int'(busy_o), 1);
      rst_n = 1'b0;
      #1;
      chk("mr_busy", int'(busy_o), 0);
      chk("mr_valid", int'(valid_o), 0);
      chk("mr_median", int'(median_o), 0);
      chk("mr_ready", int'(ready_o), 1);
      @(negedge clk);
      rst_n = 1'b1;
      rw = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
      run_window(rw, 5, "mr_next");

      // Random single windows against the reference model.
      for (int i = 0; i < 12; i++) begin
         for (int k = 0; k < 9; k++) rw[k] = int'($urandom_range(0, 255));
         if (i == 0) rw[3] = 0;
         if (i == 1) rw[5] = 255;
         run_window(rw, ref_median(rw), $sformatf("rnd%0d", i));
      end

      // Continuous valid_i/ready_i stream of 4 random windows.
      nacc = 0;
      nres = 0;
      ready_i = 1'b1;
      for (int k = 0; k < 9; k++) rw[k] = int'($urandom_range(0, 255));
      data_i  = pack(rw);
      valid_i = 1'b1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         accepted = 1'b0;
         if (valid_o && ready_i) begin
            if (expq.size() == 0) chk("str_unexpected", 1, 0);
            else chk($sformatf("str_median%0d", nres), int'(median_o), expq.pop_front());
            nres++;
         end
         if (valid_i && ready_o) begin
            acc_cyc.push_back(cyc);
            expq.push_back(ref_median(rw));
            nacc++;
            accepted = 1'b1;
         end
         @(negedge clk);
         if (accepted) begin
            if (nacc < 4) begin
               for (int k = 0; k < 9; k++) rw[k] = int'($urandom_range(0, 255));
               data_i = pack(rw);
            end else begin
               valid_i = 1'b0;
            end
         end
         if (nacc >= 4 && nres >= 4) break;
      end
      chk("str_results", nres, 4);
      chk("str_accepts", acc_cyc.size(), 4);
      for (int i = 1; i < acc_cyc.size(); i++)
         chk($sformatf("str_period%0d", i), acc_cyc[i] - acc_cyc[i-1], PERIOD);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
